// File: rtl/dunit_latch_reader_pkg.sv
// Shared types and frame constants for the EX/M latch debug reader.
package dunit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        SNAP,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] FRAME_HDR   = 8'hE4;
    localparam int         FRAME_BYTES = 16;
    localparam logic [3:0] LAST_IDX    = 4'(FRAME_BYTES - 1);

    // Byte offsets of each field inside the dump frame (multi-byte fields MSB first).
    localparam int OFS_HDR   = 0;
    localparam int OFS_PC    = 1;
    localparam int OFS_ALU   = 5;
    localparam int OFS_WDATA = 9;
    localparam int OFS_ADDR  = 13;
    localparam int OFS_CTRL  = 14;

endpackage

// File: rtl/dunit_latch_reader.sv
// Debug-unit controller: drives the pipeline clock enable and dumps a frozen
// EX/M latch snapshot as a 16-byte valid/ready frame toward the UART TX.
module dunit_latch_reader
    import dunit_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_CTRL = 9,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_dump,
    input  logic [NB_REG-1:0]  i_pc_eight,
    input  logic [NB_REG-1:0]  i_alu_result,
    input  logic [NB_REG-1:0]  i_w_data,
    input  logic [NB_ADDR-1:0] i_data_addr,
    input  logic [NB_CTRL-1:0] i_control_from_ex,
    output logic               o_dunit_clk_en,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    state_t             state;
    logic [3:0]         idx;
    logic [NB_REG-1:0]  sh_pc;
    logic [NB_REG-1:0]  sh_alu;
    logic [NB_REG-1:0]  sh_wdata;
    logic [NB_ADDR-1:0] sh_addr;
    logic [NB_CTRL-1:0] sh_ctrl;

    // Fields padded to their frame widths.
    logic [31:0] pc_w;
    logic [31:0] alu_w;
    logic [31:0] wd_w;
    logic [7:0]  addr_w;
    logic [15:0] ctrl_w;

    assign pc_w   = 32'(sh_pc);
    assign alu_w  = 32'(sh_alu);
    assign wd_w   = 32'(sh_wdata);
    assign addr_w = 8'(sh_addr);
    assign ctrl_w = 16'(sh_ctrl);

    // The mux looks one byte ahead so o_tx_data can be registered on the handshake edge.
    logic [3:0] sel_idx;
    logic [7:0] frame_byte;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_idx    = 4'(OFS_HDR);
        frame_byte = 8'h00;
        if (state == SEND) begin
            sel_idx = 4'(idx + 4'd1);
        end
        case (sel_idx)
            4'(OFS_HDR):       frame_byte = FRAME_HDR;
            4'(OFS_PC):        frame_byte = pc_w[31:24];
            4'(OFS_PC + 1):    frame_byte = pc_w[23:16];
            4'(OFS_PC + 2):    frame_byte = pc_w[15:8];
            4'(OFS_PC + 3):    frame_byte = pc_w[7:0];
            4'(OFS_ALU):       frame_byte = alu_w[31:24];
            4'(OFS_ALU + 1):   frame_byte = alu_w[23:16];
            4'(OFS_ALU + 2):   frame_byte = alu_w[15:8];
            4'(OFS_ALU + 3):   frame_byte = alu_w[7:0];
            4'(OFS_WDATA):     frame_byte = wd_w[31:24];
            4'(OFS_WDATA + 1): frame_byte = wd_w[23:16];
            4'(OFS_WDATA + 2): frame_byte = wd_w[15:8];
            4'(OFS_WDATA + 3): frame_byte = wd_w[7:0];
            4'(OFS_ADDR):      frame_byte = addr_w;
            4'(OFS_CTRL):      frame_byte = ctrl_w[15:8];
            4'(OFS_CTRL + 1):  frame_byte = ctrl_w[7:0];
            default:           frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            idx            <= 4'd0;
            o_dunit_clk_en <= 1'b0;
            o_tx_data      <= '0;
            o_tx_valid     <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            // NOTE: the shadow is a handful of flops, not a RAM, so it is cleared like any other state.
            sh_pc          <= '0;
            sh_alu         <= '0;
            sh_wdata       <= '0;
            sh_addr        <= '0;
            sh_ctrl        <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the same edge.
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_dump) begin
                        state  <= SNAP;
                        o_busy <= 1'b1;
                    end else if (i_step) begin
                        state          <= STEP;
                        o_dunit_clk_en <= 1'b1;
                    end else if (i_run) begin
                        state          <= RUN;
                        o_dunit_clk_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_dump) begin
                        state          <= SNAP;
                        o_dunit_clk_en <= 1'b0;
                        o_busy         <= 1'b1;
                    end else if (!i_run) begin
                        state          <= IDLE;
                        o_dunit_clk_en <= 1'b0;
                    end
                end
                STEP: begin
                    state          <= IDLE;
                    o_dunit_clk_en <= 1'b0;
                end
                SNAP: begin
                    sh_pc      <= i_pc_eight;
                    sh_alu     <= i_alu_result;
                    sh_wdata   <= i_w_data;
                    sh_addr    <= i_data_addr;
                    sh_ctrl    <= i_control_from_ex;
                    idx        <= 4'd0;
                    o_tx_data  <= NB_BYTE'(frame_byte);
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        if (idx == LAST_IDX) begin
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= '0;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx       <= 4'(idx + 4'd1);
                            o_tx_data <= NB_BYTE'(frame_byte);
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    if (i_run) begin
                        state          <= RUN;
                        o_dunit_clk_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    o_dunit_clk_en <= 1'b0;
                    o_tx_valid     <= 1'b0;
                    o_busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dunit_latch_reader.sv
// Scoreboard bench for dunit_latch_reader: an EX/M latch model feeds the DUT,
// expected frame bytes are queued by the stimulus and popped by a monitor.
module tb_dunit_latch_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic run = 1'b0, step = 1'b0, dump = 1'b0, tx_ready = 1'b0;

    // Latch D inputs (driven by stimulus) and Q outputs (seen by the DUT).
    logic [31:0] d_pc = '0, d_alu = '0, d_wd = '0;
    logic [4:0]  d_addr = '0;
    logic [8:0]  d_ctrl = '0;
    logic [31:0] q_pc = '0, q_alu = '0, q_wd = '0;
    logic [4:0]  q_addr = '0;
    logic [8:0]  q_ctrl = '0;

    logic       clk_en, tx_valid, busy, done;
    logic [7:0] tx_data;

    dunit_latch_reader dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_run             (run),
        .i_step            (step),
        .i_dump            (dump),
        .i_pc_eight        (q_pc),
        .i_alu_result      (q_alu),
        .i_w_data          (q_wd),
        .i_data_addr       (q_addr),
        .i_control_from_ex (q_ctrl),
        .o_dunit_clk_en    (clk_en),
        .o_tx_data         (tx_data),
        .o_tx_valid        (tx_valid),
        .i_tx_ready        (tx_ready),
        .o_busy            (busy),
        .o_done            (done)
    );

    always @(posedge clk) begin
        if (clk_en) begin
            q_pc   <= d_pc;
            q_alu  <= d_alu;
            q_wd   <= d_wd;
            q_addr <= d_addr;
            q_ctrl <= d_ctrl;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] exp_q[$];
    int         hs_count = 0;
    int         valid_rise_cyc = -1;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && !prev_valid) valid_rise_cyc = cyc;
            if (busy) check("busy_clk_en", 32'(clk_en), 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(tx_valid), 32'd0);
                end else begin
                    check($sformatf("byte%0d", hs_count), 32'(tx_data), 32'(exp_q.pop_front()));
                end
                hs_count++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_valid = tx_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [127:0] v);
        for (int i = 0; i < 16; i++) exp_q.push_back(v[127-8*i -: 8]);
        hs_count       = 0;
        valid_rise_cyc = -1;
    endtask

    task automatic set_d(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] addr, input logic [8:0] ctrl);
        d_pc = pc; d_alu = alu; d_wd = wd; d_addr = addr; d_ctrl = ctrl;
    endtask

    task automatic pulse_dump(output int edge_cyc);
        dump = 1'b1;
        tick();
        edge_cyc = cyc;
        dump = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit churn, input bit rand_ready,
                             output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget && done_cyc < 0; i++) begin
            if (churn) set_d($urandom, $urandom, $urandom, 5'($urandom), 9'($urandom));
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) done_cyc = cyc;
        end
        if (done_cyc < 0) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e;
        int dc;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk_en", 32'(clk_en), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_clk_en", 32'(clk_en), 32'd0);
        end

        // Single step loads the latch exactly once
        set_d(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 5'h1F, 9'h1FF);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_clk_en_hi", 32'(clk_en), 32'd1);
        check("step_q_before", q_pc, 32'h0);
        tick();
        check("step_clk_en_lo", 32'(clk_en), 32'd0);
        check("step_q_after", q_pc, 32'hAAAAAAAA);
        set_d(32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D, 5'h03, 9'h042);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("step_hold_clk_en", 32'(clk_en), 32'd0);
        end
        check("step_q_hold", q_pc, 32'hAAAAAAAA);

        // Dump from IDLE, ready held high
        tx_ready = 1'b1;
        load_exp(128'hE4_AAAAAAAA_BBBBBBBB_CCCCCCCC_1F_01FF);
        pulse_dump(e);
        check("snap_busy", 32'(busy), 32'd1);
        check("snap_valid", 32'(tx_valid), 32'd0);
        wait_done(60, 1'b0, 1'b0, dc);
        check("idle_first_byte_cyc", 32'(valid_rise_cyc), 32'(e + 1));
        check("idle_done_cyc", 32'(dc), 32'(e + 17));
        check("idle_hs_count", 32'(hs_count), 32'd16);
        check("idle_queue_left", 32'(exp_q.size()), 32'd0);
        tick();
        check("idle_done_pulse", 32'(done), 32'd0);
        check("idle_busy_after", 32'(busy), 32'd0);
        check("idle_clk_en_after", 32'(clk_en), 32'd0);

        // Dump from RUN with latch inputs changing every cycle
        run = 1'b1;
        tick();
        tick();
        check("run_clk_en", 32'(clk_en), 32'd1);
        for (int k = 0; k < 8; k++) begin
            set_d(32'h10000000 + k, 32'h20000000 + k, 32'h30000000 + k, 5'(k), 9'(k));
            tick();
        end
        set_d(32'h76543210, 32'h0F1E2D3C, 32'h5A5AA5A5, 5'h0C, 9'h13B);
        load_exp(128'hE4_76543210_0F1E2D3C_5A5AA5A5_0C_013B);
        pulse_dump(e);
        check("run_dump_clk_en", 32'(clk_en), 32'd0);
        wait_done(60, 1'b1, 1'b0, dc);
        check("run_q_frozen", q_pc, 32'h76543210);
        check("run_done_cyc", 32'(dc), 32'(e + 17));
        check("run_hs_count", 32'(hs_count), 32'd16);
        check("run_queue_left", 32'(exp_q.size()), 32'd0);
        tick();
        check("run_resumed", 32'(clk_en), 32'd1);
        run = 1'b0;
        tick();
        tick();
        check("run_stopped", 32'(clk_en), 32'd0);

        // Back-pressure with random ready
        set_d(32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 5'h05, 9'h0A5);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("bp_q_loaded", q_wd, 32'hDEADBEEF);
        tx_ready = 1'b0;
        load_exp(128'hE4_01234567_89ABCDEF_DEADBEEF_05_00A5);
        pulse_dump(e);
        wait_done(400, 1'b0, 1'b1, dc);
        check("bp_hs_count", 32'(hs_count), 32'd16);
        check("bp_queue_left", 32'(exp_q.size()), 32'd0);
        tick();

        // Dropped pulses during SEND, then reset mid-frame
        tx_ready = 1'b1;
        load_exp(128'hE4_01234567_89ABCDEF_DEADBEEF_05_00A5);
        pulse_dump(e);
        for (int i = 0; i < 40 && hs_count < 3; i++) tick();
        step = 1'b1;
        dump = 1'b1;
        tick();
        step = 1'b0;
        dump = 1'b0;
        for (int i = 0; i < 40 && hs_count < 7; i++) tick();
        check("abort_hs_reached", 32'(hs_count), 32'd7);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_valid", 32'(tx_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        check("post_rst_hs", 32'(hs_count), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
